// File: rtl/ad5328_setpoint_bank.sv
// rtl/ad5328_setpoint_bank.sv - shadow/active setpoint bank with commit, hold and refresh for the AD5328 driver
module ad5328_setpoint_bank #(
  parameter int          HOLD_CYCLES    = 1100,
  parameter int          REFRESH_CYCLES = 0,
  parameter logic [11:0] DEFAULT_CODE   = 12'h000
) (
  input  logic              dtc_clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [4:0]        wr_addr,
  input  logic [11:0]       wr_data,
  input  logic [4:0]        rd_addr,
  output logic [11:0]       rd_data,
  input  logic              commit,
  output logic [31:0][11:0] dac_data,
  output logic              dac_update,
  output logic              busy,
  output logic              pending,
  output logic [15:0]       update_cnt
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, UPDATE, HOLD} state_t;

  state_t            state;
  state_t            next_state;
  logic [31:0][11:0] shadow;
  logic [31:0][11:0] shadow_next;
  logic [HW-1:0]     hold_cnt;
  logic [31:0]       refresh_cnt;
  logic              refresh_hit;
  logic              do_copy;
  logic              start;

  // Shadow contents including this cycle's write, so a commit in the same cycle sees it.
  always_comb begin
    shadow_next = shadow;
    if (wr_en) begin
      shadow_next[wr_addr] = wr_data;
    end
  end

  // Next state plus copy/start decisions; commit wins over refresh.
  always_comb begin
    next_state  = state;
    do_copy     = 1'b0;
    start       = 1'b0;
    refresh_hit = (REFRESH_CYCLES > 0) && (refresh_cnt == 32'(REFRESH_CYCLES - 1));
    case (state)
      IDLE: begin
        if (commit) begin
          do_copy    = 1'b1;
          start      = 1'b1;
          next_state = UPDATE;
        end else if (refresh_hit) begin
          start      = 1'b1;
          next_state = UPDATE;
        end
      end
      UPDATE: begin
        next_state = HOLD;
      end
      HOLD: begin
        if (hold_cnt == '0) begin
          if (pending || commit) begin
            do_copy    = 1'b1;
            start      = 1'b1;
            next_state = UPDATE;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State register; busy is registered alongside it.
  always_ff @(posedge dtc_clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state != IDLE);
    end
  end

  // Banks, read-back, counters and the deferred-commit flag.
  always_ff @(posedge dtc_clk) begin
    if (rst) begin
      shadow      <= {32{DEFAULT_CODE}};
      dac_data    <= {32{DEFAULT_CODE}};
      rd_data     <= DEFAULT_CODE;
      dac_update  <= 1'b0;
      pending     <= 1'b0;
      update_cnt  <= 16'd0;
      hold_cnt    <= '0;
      refresh_cnt <= 32'd0;
    end else begin
      shadow     <= shadow_next;
      rd_data    <= shadow[rd_addr];
      dac_update <= start;
      if (do_copy) begin
        dac_data <= shadow_next;
      end
      if (state == UPDATE) begin
        update_cnt <= update_cnt + 16'd1;
        hold_cnt   <= HW'(HOLD_CYCLES - 1);
      end else if (state == HOLD && hold_cnt != '0) begin
        hold_cnt <= hold_cnt - 1'b1;
      end
      if (state == IDLE && next_state == IDLE) begin
        refresh_cnt <= refresh_cnt + 32'd1;
      end else begin
        refresh_cnt <= 32'd0;
      end
      // A commit arriving while the driver is busy (UPDATE or HOLD) is deferred.
      if (start) begin
        pending <= 1'b0;
      end else if (state != IDLE && commit) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ad5328_setpoint_bank.sv
// tb/tb_ad5328_setpoint_bank.sv - randomized and directed bench for ad5328_setpoint_bank
module tb_ad5328_setpoint_bank;

  localparam int          H   = 100;
  localparam int          R   = 200;
  localparam logic [11:0] DEF = 12'h000;

  logic              dtc_clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [4:0]        wr_addr;
  logic [11:0]       wr_data;
  logic [4:0]        rd_addr;
  logic [11:0]       rd_data;
  logic              commit;
  logic [31:0][11:0] dac_data;
  logic              dac_update;
  logic              busy;
  logic              pending;
  logic [15:0]       update_cnt;

  always #5 dtc_clk = ~dtc_clk;

  ad5328_setpoint_bank #(
    .HOLD_CYCLES(H),
    .REFRESH_CYCLES(R),
    .DEFAULT_CODE(DEF)
  ) dut (
    .dtc_clk(dtc_clk),
    .rst(rst),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .commit(commit),
    .dac_data(dac_data),
    .dac_update(dac_update),
    .busy(busy),
    .pending(pending),
    .update_cnt(update_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [383:0] got, input logic [383:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: time-based view. A pulse issued at edge S keeps the bank busy
  // until the decision edge S+H+1; idle refresh fires R edges after idle entry.
  logic [11:0] m_shadow [32];
  logic [11:0] m_active [32];
  int          n_edge  = 0;
  int          m_start = -1000000;
  int          m_entry = 0;
  bit          m_idle  = 1'b1;
  bit          m_pending;
  bit          m_upd;
  logic [15:0] m_cnt;
  logic [11:0] m_rd;

  function automatic void model_edge();
    logic [11:0] new_sh [32];
    bit go;
    bit copy;
    n_edge++;
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_shadow[i] = DEF;
        m_active[i] = DEF;
      end
      m_idle = 1'b1; m_entry = n_edge; m_start = -1000000;
      m_pending = 1'b0; m_upd = 1'b0; m_cnt = 16'd0; m_rd = DEF;
      return;
    end
    m_rd = m_shadow[rd_addr];
    new_sh = m_shadow;
    if (wr_en) new_sh[wr_addr] = wr_data;
    go = 1'b0;
    copy = 1'b0;
    if (n_edge == m_start + 1) m_cnt = m_cnt + 16'd1;
    if (!m_idle) begin
      if (n_edge < m_start + H + 1) begin
        if (commit) m_pending = 1'b1;
      end else begin
        if (m_pending || commit) begin
          go = 1'b1; copy = 1'b1;
        end else begin
          m_idle = 1'b1; m_entry = n_edge;
        end
        m_pending = 1'b0;
      end
    end else begin
      if (commit) begin
        go = 1'b1; copy = 1'b1;
      end else if (n_edge == m_entry + R) begin
        go = 1'b1;
      end
    end
    if (go) begin
      m_start = n_edge;
      m_idle = 1'b0;
      if (copy) m_active = new_sh;
    end
    m_upd = go;
    m_shadow = new_sh;
  endfunction

  task automatic step();
    logic [31:0][11:0] exp_bank;
    @(posedge dtc_clk);
    model_edge();
    #1;
    for (int i = 0; i < 32; i++) exp_bank[i] = m_active[i];
    check_eq("dac_update", 384'(dac_update), 384'(m_upd));
    check_eq("busy", 384'(busy), 384'(!m_idle));
    check_eq("pending", 384'(pending), 384'(m_pending));
    check_eq("update_cnt", 384'(update_cnt), 384'(m_cnt));
    check_eq("rd_data", 384'(rd_data), 384'(m_rd));
    check_eq("dac_data", 384'(dac_data), 384'(exp_bank));
    wr_en = 1'b0;
    commit = 1'b0;
    rst = 1'b0;
  endtask

  task automatic wait_pulse(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      step();
      if (dac_update) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (!busy) break;
      step();
    end
    check_eq("idle_timeout", 384'(busy), 384'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int p;
    int bcnt;
    logic [15:0] c0;
    logic [31:0][11:0] snap;

    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0; commit = 1'b0;
    rst = 1'b1; step();
    rst = 1'b1; step();

    // Reset read-back of every address.
    check_eq("rst_busy", 384'(busy), 384'(0));
    check_eq("rst_bank", 384'(dac_data), 384'(0));
    for (int a = 0; a < 32; a++) begin
      rd_addr = 5'(a);
      step();
      check_eq("rd_reset", 384'(rd_data), 384'(12'h000));
    end

    // First commit, then a deferred double commit during HOLD.
    wr_en = 1'b1; wr_addr = 5'd5;  wr_data = 12'hABC; step();
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 12'h123; step();
    commit = 1'b1; step();
    p = n_edge;
    check_eq("upd_after_commit", 384'(dac_update), 384'(1));
    check_eq("ch5_first", 384'(dac_data[5]), 384'(12'hABC));
    check_eq("ch31_first", 384'(dac_data[31]), 384'(12'h123));
    repeat (10) step();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 12'h111; step();
    commit = 1'b1; step();
    commit = 1'b1; step();
    check_eq("pending_set", 384'(pending), 384'(1));
    check_eq("ch5_frozen", 384'(dac_data[5]), 384'(12'hABC));
    seen = 1'b0;
    for (int i = 0; i < 2 * H; i++) begin
      step();
      if (dac_update) begin
        seen = 1'b1;
        break;
      end
      check_eq("ch5_hold", 384'(dac_data[5]), 384'(12'hABC));
    end
    check_eq("second_pulse_seen", 384'(seen), 384'(1));
    check_eq("pulse_spacing", 384'(n_edge - p), 384'(H + 1));
    check_eq("ch5_second", 384'(dac_data[5]), 384'(12'h111));
    bcnt = 1;
    for (int i = 0; i < 2 * H; i++) begin
      step();
      if (!busy) break;
      bcnt++;
    end
    check_eq("busy_len", 384'(bcnt), 384'(H + 1));
    check_eq("update_cnt_two", 384'(update_cnt), 384'(2));

    // Write and commit in the same IDLE cycle.
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 12'h7FF; commit = 1'b1; step();
    check_eq("same_cycle_upd", 384'(dac_update), 384'(1));
    check_eq("same_cycle_ch0", 384'(dac_data[0]), 384'(12'h7FF));
    wait_idle(3 * H);

    // Periodic refresh with no commits.
    wait_pulse(R + 10, seen);
    check_eq("refresh_first", 384'(seen), 384'(1));
    p = n_edge;
    snap = dac_data;
    c0 = update_cnt;
    for (int k = 1; k <= 2; k++) begin
      wait_pulse(R + H + 20, seen);
      check_eq("refresh_seen", 384'(seen), 384'(1));
      check_eq("refresh_period", 384'(n_edge - p), 384'(R + 1 + H));
      check_eq("refresh_bank", 384'(dac_data), 384'(snap));
      check_eq("refresh_cnt_inc", 384'(update_cnt), 384'(c0 + 16'(k)));
      p = n_edge;
    end

    // Reset in HOLD with a deferred commit outstanding.
    repeat (5) step();
    commit = 1'b1; step();
    check_eq("pending_before_rst", 384'(pending), 384'(1));
    rst = 1'b1; step();
    check_eq("rst_hold_busy", 384'(busy), 384'(0));
    check_eq("rst_hold_pending", 384'(pending), 384'(0));
    check_eq("rst_hold_bank", 384'(dac_data), 384'({32{DEF}}));
    bcnt = 0;
    repeat (H + 20) begin
      step();
      if (dac_update) bcnt++;
    end
    check_eq("no_upd_after_rst", 384'(bcnt), 384'(0));

    // Randomized traffic against the model.
    for (int i = 0; i < 6000; i++) begin
      wr_en   = ($urandom_range(0, 1) == 1);
      wr_addr = 5'($urandom_range(0, 31));
      wr_data = 12'($urandom);
      rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      commit  = ($urandom_range(0, 99) < 2);
      rst     = ($urandom_range(0, 1999) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
